// File: rtl/phase_onehot_sequencer_pkg.sv
// Shared types and helpers for the one-hot phase sequencer.
package phase_onehot_sequencer_pkg;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Widest one-hot vector the decode helper can produce.
   localparam int unsigned ONEHOT_MAX = 32;

   // One-hot decode of idx over n_out outputs; out-of-range indices give all zeros.
   function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx,
                                                    input int unsigned n_out);
      logic [ONEHOT_MAX-1:0] v;
      v = '0;
      if (idx < n_out && idx < ONEHOT_MAX) v = ONEHOT_MAX'(1) << idx;
      return v;
   endfunction

   // A phase index is legal when it addresses an existing output.
   function automatic logic idx_legal(input int unsigned idx, input int unsigned n_out);
      return idx < n_out;
   endfunction

endpackage

// File: rtl/phase_onehot_sequencer_if.sv
// Command/status bundle between the cycle-program FSM (master) and the sequencer (slave).
interface phase_onehot_sequencer_if #(
   parameter int SEL_W   = 3,
   parameter int N_OUT   = 2**SEL_W,
   parameter int DWELL_W = 8
);
   logic               start;
   logic [SEL_W-1:0]   start_idx;
   logic [SEL_W-1:0]   last_idx;
   logic [DWELL_W-1:0] dwell;
   logic               pause;
   logic               abort;
   logic [N_OUT-1:0]   phase_oh;
   logic [SEL_W-1:0]   phase_idx;
   logic               busy;
   logic               phase_done;
   logic               seq_done;
   logic               err;

   modport master (
      output start, start_idx, last_idx, dwell, pause, abort,
      input  phase_oh, phase_idx, busy, phase_done, seq_done, err
   );

   modport slave (
      input  start, start_idx, last_idx, dwell, pause, abort,
      output phase_oh, phase_idx, busy, phase_done, seq_done, err
   );
endinterface

// File: rtl/phase_onehot_sequencer_onehot_dec.sv
// Combinational SEL_W -> N_OUT one-hot decoder with enable.
module onehot_dec
   import phase_onehot_sequencer_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int N_OUT = 2**SEL_W
) (
   input  logic [SEL_W-1:0] idx,
   input  logic             en,
   output logic [N_OUT-1:0] oh
);

   // Decode the index when enabled, otherwise blank every output.
   always_comb begin
      oh = en ? N_OUT'(onehot(32'(idx), N_OUT)) : '0;
   end

endmodule

// File: rtl/phase_onehot_sequencer.sv
// One-hot phase driver: steps start_idx..last_idx (with wrap), dwell per phase,
// pause freezes and blanks, abort terminates. All outputs are registered.
module phase_onehot_sequencer
   import phase_onehot_sequencer_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int N_OUT   = 2**SEL_W,
   parameter int DWELL_W = 8
) (
   input logic                    clk,
   input logic                    reset,
   phase_onehot_sequencer_if.slave bus
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] RUN  = ST_RUN;
   localparam logic [1:0] HOLD = ST_HOLD;

   logic [1:0]         state,  state_nxt;
   logic [SEL_W-1:0]   idx,    idx_nxt;
   logic [SEL_W-1:0]   last,   last_nxt;
   logic [SEL_W-1:0]   idx_inc;
   logic [DWELL_W-1:0] d_lat,  d_nxt;
   logic [DWELL_W-1:0] cnt,    cnt_nxt;
   logic               pd_nxt, sd_nxt, err_nxt;
   logic [N_OUT-1:0]   oh_nxt;
   logic [N_OUT-1:0]   phase_oh_q;
   logic               phase_done_q, seq_done_q, err_q;

   // Next phase index, wrapping from the top output back to zero.
   assign idx_inc = (idx == SEL_W'(N_OUT - 1)) ? '0 : idx + SEL_W'(1);

   // Next-state and datapath decisions; priority is abort > pause > count.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nxt = state;
      idx_nxt   = idx;
      last_nxt  = last;
      d_nxt     = d_lat;
      cnt_nxt   = cnt;
      pd_nxt    = 1'b0;
      sd_nxt    = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               if (idx_legal(32'(bus.start_idx), N_OUT) && idx_legal(32'(bus.last_idx), N_OUT)) begin
                  state_nxt = RUN;
                  idx_nxt   = bus.start_idx;
                  last_nxt  = bus.last_idx;
                  cnt_nxt   = '0;
                  d_nxt     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (bus.pause) begin
               state_nxt = HOLD;
            end else if (cnt == d_lat - DWELL_W'(1)) begin
               pd_nxt = 1'b1;
               if (idx == last) begin
                  state_nxt = IDLE;
                  sd_nxt    = 1'b1;
               end else begin
                  idx_nxt = idx_inc;
                  cnt_nxt = '0;
               end
            end else begin
               cnt_nxt = cnt + DWELL_W'(1);
            end
         end
         HOLD: begin
            // Resuming only re-enables the output; counting restarts on the following edge.
            if (bus.abort)       state_nxt = IDLE;
            else if (!bus.pause) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   onehot_dec #(
      .SEL_W (SEL_W),
      .N_OUT (N_OUT)
   ) u_dec (
      .idx (idx_nxt),
      .en  (state_nxt == RUN),
      .oh  (oh_nxt)
   );

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         last         <= '0;
         d_lat        <= '0;
         cnt          <= '0;
         phase_oh_q   <= '0;
         phase_done_q <= 1'b0;
         seq_done_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         last         <= last_nxt;
         d_lat        <= d_nxt;
         cnt          <= cnt_nxt;
         phase_oh_q   <= oh_nxt;
         phase_done_q <= pd_nxt;
         seq_done_q   <= sd_nxt;
         err_q        <= err_nxt;
      end
   end

   assign bus.phase_oh   = phase_oh_q;
   assign bus.phase_idx  = idx;
   assign bus.busy       = (state != IDLE);
   assign bus.phase_done = phase_done_q;
   assign bus.seq_done   = seq_done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_phase_onehot_sequencer.sv
// Scoreboard bench: two sequencers (N_OUT=8 and N_OUT=6) share stimulus; a
// phase-level reference model predicts each cycle's outputs into queues that
// per-DUT monitors pop and compare on the falling edge.
module tb_phase_onehot_sequencer;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HOLD = 2;

   typedef struct {
      int mode;
      int phase;
      int left;
      int last;
      int d;
   } model_t;

   typedef struct {
      int oh;
      int idx;
      bit chk_idx;
      bit busy;
      bit pd;
      bit sd;
      bit err;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       start, abort, pause;
   logic [2:0] start_idx, last_idx;
   logic [7:0] dwell;

   int     checks = 0;
   int     errors = 0;
   exp_t   q8[$];
   exp_t   q6[$];
   model_t m8, m6;

   phase_onehot_sequencer_if #(.SEL_W(3), .N_OUT(8), .DWELL_W(8)) if8 ();
   phase_onehot_sequencer_if #(.SEL_W(3), .N_OUT(6), .DWELL_W(8)) if6 ();

   assign if8.start = start;  assign if8.start_idx = start_idx;  assign if8.last_idx = last_idx;
   assign if8.dwell = dwell;  assign if8.pause = pause;          assign if8.abort = abort;
   assign if6.start = start;  assign if6.start_idx = start_idx;  assign if6.last_idx = last_idx;
   assign if6.dwell = dwell;  assign if6.pause = pause;          assign if6.abort = abort;

   phase_onehot_sequencer #(.SEL_W(3), .N_OUT(8), .DWELL_W(8)) dut8 (
      .clk (clk), .reset (reset), .bus (if8)
   );
   phase_onehot_sequencer #(.SEL_W(3), .N_OUT(6), .DWELL_W(8)) dut6 (
      .clk (clk), .reset (reset), .bus (if6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Phase-level model: "left" counts run-edges remaining in the current phase.
   function automatic exp_t model_step(inout model_t m, input int n_out, input bit rst,
                                       input bit st, input bit ab, input bit pa,
                                       input int si, input int li, input int dw);
      exp_t e;
      e.pd = 0; e.sd = 0; e.err = 0;
      if (rst) begin
         m.mode = M_IDLE; m.phase = 0;
      end else begin
         case (m.mode)
            M_IDLE: if (st && !ab) begin
               if (si < n_out && li < n_out) begin
                  m.mode = M_RUN; m.phase = si; m.last = li;
                  m.d = (dw == 0) ? 1 : dw; m.left = m.d;
               end else begin
                  e.err = 1;
               end
            end
            M_RUN: begin
               if (ab)      m.mode = M_IDLE;
               else if (pa) m.mode = M_HOLD;
               else begin
                  m.left = m.left - 1;
                  if (m.left == 0) begin
                     e.pd = 1;
                     if (m.phase == m.last) begin
                        m.mode = M_IDLE; e.sd = 1;
                     end else begin
                        m.phase = (m.phase + 1) % n_out; m.left = m.d;
                     end
                  end
               end
            end
            default: begin
               if (ab)       m.mode = M_IDLE;
               else if (!pa) m.mode = M_RUN;
            end
         endcase
      end
      e.busy    = (m.mode != M_IDLE);
      e.oh      = (m.mode == M_RUN) ? (1 << m.phase) : 0;
      e.idx     = rst ? 0 : m.phase;
      e.chk_idx = e.busy || rst;
      return e;
   endfunction

   task automatic compare(input string name, input exp_t e, input int oh, input int idx,
                          input bit busy, input bit pd, input bit sd, input bit err);
      checks++;
      if (oh != e.oh || busy != e.busy || pd != e.pd || sd != e.sd || err != e.err ||
          (e.chk_idx && idx != e.idx)) begin
         errors++;
         $display("FAIL %s t=%0t: got oh=%h idx=%0d busy=%b pd=%b sd=%b err=%b, want oh=%h idx=%0d busy=%b pd=%b sd=%b err=%b",
                  name, $time, oh, idx, busy, pd, sd, err, e.oh, e.idx, e.busy, e.pd, e.sd, e.err);
      end
   endtask

   // Monitor for the 8-output instance.
   always @(negedge clk) begin
      if (q8.size() > 0) begin
         exp_t e;
         e = q8.pop_front();
         compare("n8", e, int'(if8.phase_oh), int'(if8.phase_idx), if8.busy,
                 if8.phase_done, if8.seq_done, if8.err);
      end
   end

   // Monitor for the 6-output instance.
   always @(negedge clk) begin
      if (q6.size() > 0) begin
         exp_t e;
         e = q6.pop_front();
         compare("n6", e, int'(if6.phase_oh), int'(if6.phase_idx), if6.busy,
                 if6.phase_done, if6.seq_done, if6.err);
      end
   end

   task automatic drive(input bit rst, input bit st, input bit ab, input bit pa,
                        input int si, input int li, input int dw);
      @(negedge clk);
      #1;
      reset = rst; start = st; abort = ab; pause = pa;
      start_idx = si[2:0]; last_idx = li[2:0]; dwell = dw[7:0];
      q8.push_back(model_step(m8, 8, rst, st, ab, pa, si, li, dw));
      q6.push_back(model_step(m6, 6, rst, st, ab, pa, si, li, dw));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic go(input int si, input int li, input int dw);
      drive(0, 1, 0, 0, si, li, dw);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
      start_idx = '0; last_idx = '0; dwell = '0;
      m8 = '{M_IDLE, 0, 0, 0, 1};
      m6 = '{M_IDLE, 0, 0, 0, 1};

      // Reset state.
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 2, 4, 3);
      idle(2);
      // 2..4, dwell 3.
      go(2, 4, 3);          idle(12);
      // Wrap 6..1 dwell 1 (illegal on the 6-output instance).
      go(6, 1, 1);          idle(8);
      // dwell 0 behaves as 1.
      go(0, 2, 0);          idle(6);
      // Pause 5 cycles after one counted cycle of a 4-cycle phase.
      go(2, 4, 4);          idle(1);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, 0);
      idle(14);
      // Out-of-range start index.
      go(7, 2, 2);          idle(8);
      // Abort mid-run.
      go(1, 5, 2);          idle(4);
      drive(0, 0, 1, 0, 0, 0, 0); idle(4);
      // Abort while held.
      go(0, 3, 2);          idle(1);
      drive(0, 0, 0, 1, 0, 0, 0); drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0, 0); idle(3);
      // Start and new parameters while busy are ignored.
      go(0, 3, 2);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 5, 5, 1);
      idle(6);
      // Abort together with start in IDLE.
      drive(0, 1, 1, 0, 1, 2, 2); idle(3);
      // Reset mid-run.
      go(0, 5, 3);          idle(3);
      drive(1, 0, 0, 0, 0, 0, 0); idle(3);
      // Single phase at the top index, and wrap on the 6-output instance.
      go(7, 7, 2);          idle(4);
      go(5, 0, 2);          idle(6);
      go(5, 5, 1);          idle(3);

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         bit r, s, a, p;
         r = ($urandom_range(0, 199) == 0);
         a = ($urandom_range(0, 39) == 0);
         s = !a && ($urandom_range(0, 5) == 0);
         p = ($urandom_range(0, 7) == 0);
         drive(r, s, a, p, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 5)));
      end
      idle(2);

      // Let the monitors drain what is still queued.
      for (int i = 0; i < 5 && (q8.size() > 0 || q6.size() > 0); i++) @(negedge clk);
      @(posedge clk);
      checks++;
      if (q8.size() != 0 || q6.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d queued, want 0/0", q8.size(), q6.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
